// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper serial link.
//   state_t       : transmitter FSM states (IDLE, SHIFT)
//   MIN_LENGTH    : smallest legal word width
//   MIN_DIV       : smallest legal bit-period divider
//   length_legal  : true when a word width can be serialized
//   div_legal     : true when a divider value is usable
package stepper_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int MIN_LENGTH = 2;
  localparam int MIN_DIV    = 1;

  function automatic bit length_legal(input int length);
    return length >= MIN_LENGTH;
  endfunction

  function automatic bit div_legal(input int div);
    return div >= MIN_DIV;
  endfunction

endpackage

// File: rtl/shift_serializer_if.sv
// Word-load handshake between the step-command logic and the serializer.
//   load_data  : word to transmit
//   load_down  : 1 = LSB first, 0 = MSB first
//   load_valid : load_data/load_down are valid
//   load_ready : serializer can take a word this cycle
// Modports: master = word source, slave = serializer.
interface shift_serializer_if #(
  parameter int LENGTH = 8
);

  logic [LENGTH-1:0] load_data;
  logic              load_down;
  logic              load_valid;
  logic              load_ready;

  modport master (
    output load_data,
    output load_down,
    output load_valid,
    input  load_ready
  );

  modport slave (
    input  load_data,
    input  load_down,
    input  load_valid,
    output load_ready
  );

endinterface

// File: rtl/bit_tick_gen.sv
// Bit-period divider for the serializer.
//   clk  : clock
//   clr  : asynchronous active-high clear
//   run  : count enable; the count is held at 0 while low
//   tick : high on the last clock of every DIV-cycle bit period
module bit_tick_gen
  import stepper_pkg::*;
#(
  parameter int DIV = 4,
  parameter int CW  = $clog2(DIV) + 1
) (
  input  logic clk,
  input  logic clr,
  input  logic run,
  output logic tick
);

  if (!div_legal(DIV)) begin : g_bad_div
    $error("bit_tick_gen: DIV must be at least 1");
  end

  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Holding the count at 0 while idle means every frame starts with a
  // full bit period, including one accepted on the done cycle.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt <= '0;
    end else if (!run || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = run && (cnt == LAST);

endmodule

// File: rtl/shift_serializer.sv
// Parallel-in, serial-out transmitter feeding a shift_register receiver.
//   clk      : clock
//   clr      : asynchronous active-high reset; aborts a frame with no done
//   load     : word handshake (slave side)
//   data_out : current serial bit, held for a full bit period
//   ce_out   : one-cycle strobe, receiver samples data_out on its posedge
//   down_out : direction latched for the frame (1 = LSB first)
//   busy     : frame in progress
//   done     : one-cycle pulse in the first idle cycle after a frame
module shift_serializer
  import stepper_pkg::*;
#(
  parameter int LENGTH = 8,
  parameter int DIV    = 4,
  parameter int CW     = $clog2(DIV) + 1,
  parameter int BW     = $clog2(LENGTH) + 1
) (
  input  logic               clk,
  input  logic               clr,
  shift_serializer_if.slave  load,
  output logic               data_out,
  output logic               ce_out,
  output logic               down_out,
  output logic               busy,
  output logic               done
);

  if (!length_legal(LENGTH)) begin : g_bad_length
    $error("shift_serializer: LENGTH must be at least 2");
  end

  localparam logic [BW-1:0] LAST_BIT = BW'(LENGTH - 1);

  state_t            state;
  logic [LENGTH-1:0] shreg;
  logic [BW-1:0]     bit_cnt;
  logic              tick;
  logic              accept;

  assign busy           = (state == SHIFT);
  assign load.load_ready = (state == IDLE);
  assign accept         = load.load_valid && (state == IDLE);
  assign ce_out         = tick;

  // The output end of shreg depends on the latched direction; idle forces 0.
  assign data_out = busy && (down_out ? shreg[0] : shreg[LENGTH-1]);

  bit_tick_gen #(
    .DIV (DIV),
    .CW  (CW)
  ) u_tick (
    .clk  (clk),
    .clr  (clr),
    .run  (busy),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      down_out <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            shreg    <= load.load_data;
            down_out <= load.load_down;
            bit_cnt  <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick) begin
            // Move the next bit toward the output end, zero-filling behind it.
            shreg   <= down_out ? (shreg >> 1) : (shreg << 1);
            bit_cnt <= bit_cnt + BW'(1);
            if (bit_cnt == LAST_BIT) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/shift_serializer.md
Name: shift_serializer

Overview:
- Parallel-in, serial-out transmitter. It is the sending end of the serial link whose receiving end is the team's `shift_register` (serial in, parallel out, `ce`/`down` controlled).
- Accepts a LENGTH-bit word through a valid/ready handshake and shifts it out one bit per bit period.
- Produces a one-cycle `ce_out` strobe per bit, so `data_out`/`ce_out`/`down_out` drive the receiver's `data`/`ce`/`down` directly.
- Sits between the step-command logic and the coil-pattern shift registers.

Parameters:
- LENGTH, 8: word width in bits; must be at least 2.
- DIV, 4: clk cycles per bit period; must be at least 1.
- CW, $clog2(DIV)+1: width of the divider counter.
- BW, $clog2(LENGTH)+1: width of the bit counter.

Ports:
- clk  in  1  clock; all state changes on posedge.
- clr  in  1  reset, asynchronous and active-high.
- load_data  in  LENGTH  word to transmit.
- load_down  in  1  direction for this word: 1 = LSB first (pairs with receiver down=1), 0 = MSB first.
- load_valid  in  1  load_data/load_down are valid.
- load_ready  out  1  block can accept a word this cycle.
- data_out  out  1  current serial bit.
- ce_out  out  1  one-cycle strobe; receiver samples data_out on this cycle's posedge.
- down_out  out  1  latched direction, held for the whole frame.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after the last bit.

Behaviour:
- Reset values while clr is high: state=IDLE, load_ready=1, data_out=0, ce_out=0, down_out=0, busy=0, done=0, all counters 0.
- Reset is asynchronous; asserting clr mid-frame aborts the frame immediately, with no done pulse.
- States: IDLE, SHIFT.
- IDLE:
  - load_ready=1, busy=0, data_out=0.
  - Acceptance: load_valid & load_ready at a posedge.
  - On acceptance, latch load_data into shreg and load_down into down_out; clear div_cnt and bit_cnt; go to SHIFT.
- SHIFT timing:
  - load_ready=0, busy=1.
  - data_out = shreg[0] if down_out, else shreg[LENGTH-1].
  - The first bit appears the cycle after acceptance.
  - div_cnt counts 0..DIV-1. ce_out=1 exactly when div_cnt==DIV-1, so data_out is stable for the whole bit period.
- SHIFT bit advance (on the posedge where ce_out=1):
  - Shift shreg toward the output end: right if down_out, left otherwise, filling with 0.
  - Increment bit_cnt.
  - If bit_cnt==LENGTH-1, go to IDLE and register done=1 for the next cycle.
- Timing:
  - A frame lasts exactly LENGTH*DIV cycles in SHIFT.
  - done is high in the first IDLE cycle. load_ready is also 1 in that cycle, so a word accepted then starts the next frame with no gap.
  - Back-to-back throughput: one word per LENGTH*DIV+1 cycles.
- DIV=1: ce_out is high every SHIFT cycle.
- load_valid while busy: ignored, with no side effects. The upstream source must hold its word until load_ready is seen.
- Data and direction inputs are sampled only at acceptance; changes during a frame have no effect.
- All outputs are registered or decoded from registered state. There is no combinational path from inputs to outputs except load_ready, which depends on state only.
- Loopback invariant: a receiver with ce=ce_out, data=data_out, down=down_out, starting from any contents, holds q==load_data after the frame.

Decomposition:
- Shared package `stepper_pkg`: state enum (IDLE, SHIFT) and a width-check localparam/function used for the LENGTH and DIV legality assertions.
- One natural sub-module, `bit_tick_gen`: parameter DIV; ports clk, clr, run, tick.
  - Counts while run=1 and asserts tick at count DIV-1.
  - Clears to 0 when run=0.
  - Drives ce_out and the shift/bit-count advance.

Test Plan:
1. LENGTH=8, DIV=4; accept 8'hA5 with load_down=0 at cycle 0.
   - data_out bits are 1,0,1,0,0,1,0,1, each held 4 cycles starting at cycle 1.
   - ce_out pulses at cycles 4,8,...,32.
   - done=1 and load_ready=1 at cycle 33.
2. Same setup, load 8'h01 with load_down=1: data_out=1 for cycles 1-4, then 0 for the rest of the frame; down_out=1 throughout.
3. Loopback into `shift_register` (LENGTH=8) for words 8'h3C/down=0 and 8'hC3/down=1: after each done, q equals the loaded word.
4. Back-to-back: hold load_valid=1 with 8'hFF then 8'h00.
   - The second frame accepts on the done cycle and its first bit appears the next cycle.
   - A third load_valid during busy is not accepted until the next done.
5. Reset mid-frame: assert clr at cycle 10 of a frame.
   - Same cycle: data_out=0, ce_out=0, busy=0, load_ready=1, and no done afterwards.
   - A new word after clr deasserts transmits correctly.
6. DIV=1, LENGTH=4; load 4'b1001 with down=0: data_out is 1,0,0,1 over cycles 1-4, ce_out=1 on all four cycles, done at cycle 5.
